// File: rtl/led_pkg.sv
// Shared types and the round-robin search helper for the LED bank arbiter.
// Purely combinational content; no latency or flow-control implications.
package led_pkg;

    localparam int unsigned RR_MAX = 8;
    localparam int unsigned RR_IW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OWN  = 2'd2
    } led_arb_state_t;

    typedef struct packed {
        logic             vld;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First asserted request at or after ptr, wrapping modulo n, optionally skipping one index.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] req,
        input logic [RR_IW-1:0]  ptr,
        input logic              excl_en,
        input logic [RR_IW-1:0]  excl_idx,
        input int unsigned       n
    );
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            k = 32'(ptr) + i;
            if (k >= n) begin
                k = k - n;
            end
            if (i < n && !res.vld && req[k[RR_IW-1:0]] &&
                !(excl_en && excl_idx == k[RR_IW-1:0])) begin
                res.vld = 1'b1;
                res.idx = k[RR_IW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin request search with an optional excluded index.
// Zero latency; no backpressure.
module rr_picker
    import led_pkg::*;
#(
    parameter  int REQ_NUM = 3,
    localparam int IDW     = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    input  logic               i_excl_en,
    input  logic [IDW-1:0]     i_excl_idx,
    output logic               o_vld,
    output logic [IDW-1:0]     o_idx
);

    logic [RR_MAX-1:0] w_req;
    logic [RR_IW-1:0]  w_ptr;
    logic [RR_IW-1:0]  w_excl;
    rr_pick_t          w_pick;

    always_comb begin
        w_req                = '0;
        w_req[REQ_NUM-1:0]   = i_req;
        w_ptr                = '0;
        w_ptr[IDW-1:0]       = i_ptr;
        w_excl               = '0;
        w_excl[IDW-1:0]      = i_excl_idx;
        w_pick               = rr_pick(w_req, w_ptr, i_excl_en, w_excl, REQ_NUM);
    end

    assign o_vld = w_pick.vld;
    assign o_idx = w_pick.idx[IDW-1:0];

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the LED bank with minimum hold and maximum slice per grant.
// Grant/switch registered 1 cycle after request; leds 1 cycle after owner; en=0 freezes everything.
module led_share_arbiter
    import led_pkg::*;
#(
    parameter  int                 REQ_NUM      = 3,
    parameter  int                 LED_NUM      = 4,
    parameter  int                 HOLD_CYC     = 16,
    parameter  int                 MAX_CYC      = 1024,
    parameter  logic [LED_NUM-1:0] IDLE_PATTERN = '0,
    localparam int                 IDW          = $clog2(REQ_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [REQ_NUM-1:0]         req,
    input  logic [REQ_NUM*LED_NUM-1:0] pattern,
    output logic [REQ_NUM-1:0]         grant,
    output logic                       owner_vld,
    output logic [IDW-1:0]             owner_id,
    output logic                       switch_p,
    output logic [LED_NUM-1:0]         leds
);

    localparam int CW = $clog2(MAX_CYC + 1);

    led_arb_state_t     r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [IDW-1:0]     r_rr_ptr, w_ptr_nxt, w_win_ptr;
    logic [IDW-1:0]     r_owner, w_owner_nxt;
    logic               r_owner_vld, w_owner_vld_nxt;
    logic [REQ_NUM-1:0] r_grant, w_grant_nxt;
    logic               r_switch, w_switch_nxt;
    logic [LED_NUM-1:0] r_leds, w_leds_nxt;
    logic               w_pick_vld;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_active, w_release;

    // Outside IDLE the search always skips the current owner, so a release hands over directly.
    rr_picker #(.REQ_NUM(REQ_NUM)) u_picker (
        .i_req      (req),
        .i_ptr      (r_rr_ptr),
        .i_excl_en  (r_state != IDLE),
        .i_excl_idx (r_owner),
        .o_vld      (w_pick_vld),
        .o_idx      (w_pick_idx)
    );

    assign w_win_ptr = (w_pick_idx == IDW'(REQ_NUM - 1)) ? '0 : w_pick_idx + IDW'(1);
    assign w_cnt_inc = (r_cnt >= CW'(MAX_CYC)) ? CW'(MAX_CYC) : r_cnt + CW'(1);
    // The cycle that completes HOLD already behaves as OWN, so a grant lasts exactly HOLD_CYC cycles.
    assign w_active  = (r_state == OWN) || (r_state == HOLD && r_cnt >= CW'(HOLD_CYC));
    assign w_release = w_active && (!req[r_owner] || (r_cnt >= CW'(MAX_CYC) && w_pick_vld));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_grant     <= '0;
            r_switch    <= 1'b0;
            r_leds      <= IDLE_PATTERN;
        end else if (en) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_owner_vld <= w_owner_vld_nxt;
            r_grant     <= w_grant_nxt;
            r_switch    <= w_switch_nxt;
            r_leds      <= w_leds_nxt;
        end else begin
            r_switch    <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_owner_vld_nxt = r_owner_vld;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt     = HOLD;
                    w_cnt_nxt       = CW'(1);
                    w_ptr_nxt       = w_win_ptr;
                    w_owner_nxt     = w_pick_idx;
                    w_owner_vld_nxt = 1'b1;
                end
            end
            HOLD, OWN: begin
                if (w_release && w_pick_vld) begin
                    w_state_nxt     = HOLD;
                    w_cnt_nxt       = CW'(1);
                    w_ptr_nxt       = w_win_ptr;
                    w_owner_nxt     = w_pick_idx;
                    w_owner_vld_nxt = 1'b1;
                end else if (w_release) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = '0;
                    w_owner_nxt     = '0;
                    w_owner_vld_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_active) begin
                        w_state_nxt = OWN;
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_cnt_nxt       = '0;
                w_owner_nxt     = '0;
                w_owner_vld_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        if (w_owner_vld_nxt) begin
            w_grant_nxt[w_owner_nxt] = 1'b1;
        end
        w_switch_nxt = (w_owner_vld_nxt != r_owner_vld) ||
                       (w_owner_vld_nxt && (w_owner_nxt != r_owner));
        w_leds_nxt   = r_owner_vld ? pattern[32'(r_owner)*LED_NUM +: LED_NUM] : IDLE_PATTERN;
    end

    assign grant     = r_grant;
    assign owner_vld = r_owner_vld;
    assign owner_id  = r_owner;
    assign switch_p  = r_switch;
    assign leds      = r_leds;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter: stimulus queues expected snapshots and switch events,
// a monitor compares them on the falling clock edge.
module tb_led_share_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b1;
    logic [2:0]  req   = 3'b000;
    logic [11:0] pattern = {4'hC, 4'hA, 4'h5};
    logic [2:0]  grant;
    logic        owner_vld;
    logic [1:0]  owner_id;
    logic        switch_p;
    logic [3:0]  leds;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int t0;

    typedef struct {
        int         cyc;
        logic [2:0] g;
        logic       ov;
        logic [1:0] id;
        logic [3:0] l;
        string      nm;
    } exp_t;

    exp_t snap_q[$];
    exp_t sw_q[$];
    exp_t e;

    led_share_arbiter #(
        .REQ_NUM(3), .LED_NUM(4), .HOLD_CYC(16), .MAX_CYC(32), .IDLE_PATTERN(4'h9)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .pattern(pattern),
        .grant(grant), .owner_vld(owner_vld), .owner_id(owner_id),
        .switch_p(switch_p), .leds(leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (switch_p === 1'b1) begin
            tests++;
            if (sw_q.size() == 0) begin
                fails++;
                $display("FAIL switch_unexpected cyc=%0d got grant=%b id=%0d vld=%b, required no switch",
                         cyc, grant, owner_id, owner_vld);
            end else begin
                e = sw_q.pop_front();
                if (e.cyc != cyc || {grant, owner_vld, owner_id} !== {e.g, e.ov, e.id}) begin
                    fails++;
                    $display("FAIL sw_%s got cyc=%0d grant=%b vld=%b id=%0d, required cyc=%0d grant=%b vld=%b id=%0d",
                             e.nm, cyc, grant, owner_vld, owner_id, e.cyc, e.g, e.ov, e.id);
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            e = snap_q.pop_front();
            tests++;
            if (e.cyc != cyc || {grant, owner_vld, owner_id, leds} !== {e.g, e.ov, e.id, e.l}) begin
                fails++;
                $display("FAIL %s cyc=%0d got grant=%b vld=%b id=%0d leds=%h, required cyc=%0d grant=%b vld=%b id=%0d leds=%h",
                         e.nm, cyc, grant, owner_vld, owner_id, leds, e.cyc, e.g, e.ov, e.id, e.l);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic exp_snap(input string nm, input int t, input logic [2:0] g, input logic ov,
                            input logic [1:0] id, input logic [3:0] l);
        snap_q.push_back('{t, g, ov, id, l, nm});
    endtask

    task automatic exp_sw(input string nm, input int t, input logic [2:0] g, input logic ov,
                          input logic [1:0] id);
        sw_q.push_back('{t, g, ov, id, 4'h0, nm});
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        goto(3);
        exp_snap("reset", 3, 3'b000, 1'b0, 2'd0, 4'h9);
        goto(4);
        rst_n = 1'b1;
        goto(5);

        // Round robin under full contention, then handover from owner 2 to 0
        t0 = cyc;
        req = 3'b111;
        exp_sw  ("rr0",       t0+1,  3'b001, 1'b1, 2'd0);
        exp_snap("rr0_end",   t0+32, 3'b001, 1'b1, 2'd0, 4'h5);
        exp_sw  ("rr1",       t0+33, 3'b010, 1'b1, 2'd1);
        exp_snap("rr1_start", t0+33, 3'b010, 1'b1, 2'd1, 4'h5);
        exp_snap("rr1_led",   t0+34, 3'b010, 1'b1, 2'd1, 4'hA);
        exp_snap("rr1_end",   t0+64, 3'b010, 1'b1, 2'd1, 4'hA);
        exp_sw  ("rr2",       t0+65, 3'b100, 1'b1, 2'd2);
        exp_snap("rr2_start", t0+65, 3'b100, 1'b1, 2'd2, 4'hA);
        exp_snap("rr2_led",   t0+66, 3'b100, 1'b1, 2'd2, 4'hC);
        exp_sw  ("rr3",       t0+97, 3'b001, 1'b1, 2'd0);
        exp_snap("rr3_start", t0+97, 3'b001, 1'b1, 2'd0, 4'hC);
        goto(t0+97);
        req = 3'b101;
        exp_sw  ("ho_in",     t0+129, 3'b100, 1'b1, 2'd2);
        exp_snap("ho_in_led", t0+130, 3'b100, 1'b1, 2'd2, 4'hC);
        goto(t0+150);
        req = 3'b001;
        exp_snap("ho_before", t0+150, 3'b100, 1'b1, 2'd2, 4'hC);
        exp_sw  ("handover",  t0+151, 3'b001, 1'b1, 2'd0);
        exp_snap("handover",  t0+151, 3'b001, 1'b1, 2'd0, 4'hC);
        exp_snap("ho_led",    t0+152, 3'b001, 1'b1, 2'd0, 4'h5);
        goto(t0+152);
        req = 3'b000;
        exp_sw  ("ho_idle",     t0+167, 3'b000, 1'b0, 2'd0);
        exp_snap("ho_idle",     t0+167, 3'b000, 1'b0, 2'd0, 4'h5);
        exp_snap("ho_idle_led", t0+168, 3'b000, 1'b0, 2'd0, 4'h9);
        goto(t0+170);

        // Single requester; rr_ptr is 1 here
        t0 = cyc;
        req = 3'b010;
        exp_sw  ("single",     t0+1,  3'b010, 1'b1, 2'd1);
        exp_snap("single_g",   t0+1,  3'b010, 1'b1, 2'd1, 4'h9);
        exp_snap("single_led", t0+2,  3'b010, 1'b1, 2'd1, 4'hA);
        goto(t0+20);
        req = 3'b000;
        exp_sw  ("single_rel",  t0+21, 3'b000, 1'b0, 2'd0);
        exp_snap("single_rel",  t0+21, 3'b000, 1'b0, 2'd0, 4'hA);
        exp_snap("single_idle", t0+22, 3'b000, 1'b0, 2'd0, 4'h9);
        goto(t0+24);

        // Minimum hold after a one-cycle pulse; rr_ptr is 2 here
        t0 = cyc;
        req = 3'b001;
        exp_sw  ("hold",       t0+1,  3'b001, 1'b1, 2'd0);
        exp_snap("hold_g",     t0+1,  3'b001, 1'b1, 2'd0, 4'h9);
        exp_snap("hold_led",   t0+2,  3'b001, 1'b1, 2'd0, 4'h5);
        exp_snap("hold_last",  t0+16, 3'b001, 1'b1, 2'd0, 4'h5);
        exp_sw  ("hold_rel",   t0+17, 3'b000, 1'b0, 2'd0);
        exp_snap("hold_rel",   t0+17, 3'b000, 1'b0, 2'd0, 4'h5);
        exp_snap("hold_idle",  t0+18, 3'b000, 1'b0, 2'd0, 4'h9);
        goto(t0+1);
        req = 3'b000;
        goto(t0+20);

        // Enable freeze for 50 cycles during HOLD; rr_ptr is 1 here
        t0 = cyc;
        req = 3'b100;
        exp_sw  ("frz",        t0+1,  3'b100, 1'b1, 2'd2);
        exp_snap("frz_led",    t0+2,  3'b100, 1'b1, 2'd2, 4'hC);
        exp_snap("frz_mid",    t0+30, 3'b100, 1'b1, 2'd2, 4'hC);
        exp_snap("frz_end",    t0+55, 3'b100, 1'b1, 2'd2, 4'hC);
        exp_snap("frz_live",   t0+56, 3'b100, 1'b1, 2'd2, 4'h3);
        exp_snap("frz_last",   t0+66, 3'b100, 1'b1, 2'd2, 4'h3);
        exp_sw  ("frz_rel",    t0+67, 3'b000, 1'b0, 2'd0);
        exp_snap("frz_rel",    t0+67, 3'b000, 1'b0, 2'd0, 4'h3);
        exp_snap("frz_idle",   t0+68, 3'b000, 1'b0, 2'd0, 4'h9);
        goto(t0+5);
        en = 1'b0;
        goto(t0+10);
        req = 3'b000;
        pattern[11:8] = 4'h3;
        goto(t0+55);
        en = 1'b1;
        goto(t0+70);
        pattern[11:8] = 4'hC;

        // Asynchronous reset while owner 1 is in OWN
        t0 = cyc;
        req = 3'b010;
        exp_sw("rst_pre", t0+1, 3'b010, 1'b1, 2'd1);
        goto(t0+20);
        #2 rst_n = 1'b0;
        exp_snap("rst_mid", t0+20, 3'b000, 1'b0, 2'd0, 4'h9);
        req = 3'b110;
        goto(t0+22);
        rst_n = 1'b1;
        exp_sw  ("rst_win",  t0+23, 3'b010, 1'b1, 2'd1);
        exp_snap("rst_win",  t0+23, 3'b010, 1'b1, 2'd1, 4'h9);
        exp_snap("rst_led",  t0+24, 3'b010, 1'b1, 2'd1, 4'hA);
        goto(t0+27);

        tests++;
        if (snap_q.size() != 0 || sw_q.size() != 0) begin
            fails++;
            $display("FAIL queues_drained got snap=%0d sw=%0d pending, required 0 and 0",
                     snap_q.size(), sw_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_share_arbiter.md
# led_share_arbiter

Round-robin arbiter that shares the PL LED bank between several pattern sources: the blink/running-light generator, PS debug writes and a fault indicator. It grants the bank to one requester at a time, with a guaranteed minimum hold time and a maximum time slice. It drives the registered `leds` output in place of the single-source LED driver under the top level, in the PS fabric-clock domain.

## Interface
- `REQ_NUM`, 3: number of requesters, 2..8
- `LED_NUM`, 4: LED bank width
- `HOLD_CYC`, 16: minimum grant duration in cycles, ≥1
- `MAX_CYC`, 1024: time slice after which a contested owner is released, ≥`HOLD_CYC`
- `IDLE_PATTERN`, '0: LED value when no owner

Ports:
- `clk` in 1: fabric clock
- `rst_n` in 1: asynchronous active-low reset
- `en` in 1: arbitration enable; 0 freezes the FSM and counters, outputs hold
- `req` in `REQ_NUM`: per-requester request level
- `pattern` in `REQ_NUM*LED_NUM`: flat; requester i owns bits `[i*LED_NUM +: LED_NUM]`
- `grant` out `REQ_NUM`: one-hot or zero, registered
- `owner_vld` out 1: a grant is active
- `owner_id` out `$clog2(REQ_NUM)`: index of the current owner; 0 when idle
- `switch_p` out 1: one-cycle pulse on every ownership change, including to or from idle
- `leds` out `LED_NUM`: registered LED drive

## Operation
- Three FSM states: IDLE, HOLD, OWN.
- **Reset values:** state IDLE, `grant`=0, `owner_vld`=0, `owner_id`=0, `switch_p`=0, `leds`=`IDLE_PATTERN`, `rr_ptr`=0, `slice_cnt`=0.
- **Round-robin selection:** search `req` starting at index `rr_ptr` and wrap modulo `REQ_NUM`. The first asserted index wins. On each grant, `rr_ptr` ← winner+1 mod `REQ_NUM`.
- **IDLE:**
  - If any `req` is set: grant the winner, go to HOLD, `slice_cnt`←1.
  - Otherwise stay in IDLE.
- **HOLD:**
  - The owner keeps the grant even if its `req` drops.
  - `slice_cnt` increments each cycle.
  - When `slice_cnt`==`HOLD_CYC`, go to OWN.
- **OWN:** `slice_cnt` increments and saturates at `MAX_CYC`. The owner is released when either:
  - (a) its own `req` is 0, or
  - (b) `slice_cnt`≥`MAX_CYC` and another `req` is set.
- **On release, the same-cycle decision picks the next state:**
  - Next winner among `req` excluding the releasing owner → grant it directly, enter HOLD, `slice_cnt`←1.
  - No other request → IDLE, `grant`=0.
  - Condition (a) and other requests in the same cycle: (a) takes precedence, and the new winner is granted.
- **LED drive:**
  - `leds` ← `pattern[owner]` each cycle while `owner_vld`; otherwise `IDLE_PATTERN`.
  - While in HOLD with a dropped `req`, the live pattern is still used.
- `en`=0: the state, counters, `rr_ptr` and `leds` all hold, and `switch_p` is 0.
- Reset mid-grant clears everything asynchronously. Arbitration resumes from `rr_ptr`=0.

## Timing
- `req` set in cycle t while IDLE → `grant`, `owner_vld`, `owner_id` and `switch_p` appear at t+1. `leds` shows that requester's pattern at t+2.
- Minimum grant length is `HOLD_CYC` cycles.
- Owner drop in OWN at cycle t → the new grant, or zero, appears at t+1. There is no gap cycle between owners.
- A contested owner is released no earlier than `MAX_CYC` cycles after its grant.
- `pattern` changes propagate to `leds` with a latency of 1 cycle.
- **Counter width:** `$clog2(MAX_CYC+1)`. It saturates and never wraps.

## Structure
- Shared package `led_pkg`:
  - state enum `led_arb_state_t` {IDLE, HOLD, OWN}
  - helper function `rr_pick(req, ptr, exclude)` returning {valid, index}
- One sub-module, `rr_picker`: combinational round-robin search. The masked-request variant is selected by an exclude input.
- The FSM, counters and output registers stay in `led_share_arbiter`.

## Test plan
- **Single requester:** `req`=3'b010 from cycle 5, `pattern[1]`=4'hA → `grant`=3'b010 at cycle 6, `leds`=4'hA at cycle 7, `switch_p` high only at cycle 6.
- **Minimum hold:** `HOLD_CYC`=16, `req[0]` pulsed for 1 cycle → `grant[0]` stays high for exactly 16 cycles, then `grant`=0 and `leds`=`IDLE_PATTERN`.
- **Round robin:** `req`=3'b111 held, `MAX_CYC`=32 → grants rotate 0→1→2→0, each lasting 32 cycles, with no idle cycle between them.
- **Handover:** owner 2 drops `req` in OWN while `req[0]` is set → `grant` changes from 3'b100 to 3'b001 in the next cycle, with `owner_id`=0.
- **Enable freeze:** `en`=0 for 50 cycles during HOLD → `grant`, `leds` and `slice_cnt` are unchanged; HOLD completes on schedule once `en`=1.
- **Reset mid-operation:** `rst_n` low asynchronously while owner 1 is in OWN → all outputs return to their reset values immediately. After release with `req`=3'b110, requester 1 wins, since `rr_ptr` is 0 and index 0 is not requesting.
